pac_ctrl: RTL

Motion and animation controller for the player sprite in the VGA maze game. Once per video frame it advances the sprite centre (`midx`, `midy`) in the direction requested by the push-buttons, clamps it to the playfield and stops at the walls. It also generates the mouth-open/closed animation phase. Its outputs drive the centre and animation inputs of the sprite pixel generator; the pixel generator itself is unchanged.

---
 rtl/pac_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/pac_ctrl.sv
// pac_ctrl -- player sprite motion and animation controller.
//
// Once per video frame (frame_tick) the sprite centre is advanced by STEP
// pixels along the current heading, clamped to the playfield, and the
// mouth animation phase is advanced while the sprite is moving.
//
// Ports
//   clk         system/pixel clock, rising edge
//   rst_n       asynchronous active-low reset
//   frame_tick  one-cycle pulse per frame
//   btn_up/down/left/right  debounced level direction requests
//   pause       level; freezes motion and animation
//   midx, midy  sprite centre (10 bit)
//   dir         heading: 0 right, 1 left, 2 up, 3 down
//   mouth_open  animation phase, 1 = open
//   moving      high only while in MOVE
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no heading yet, waits for the first request on a tick
// MOVE     | steps along dir on every tick, mouth animates
// BLOCKED  | stopped at a wall, waits for a request that leaves it
// PAUSED   | ticks ignored, animation frozen, pre-pause state kept

module pac_ctrl #(
  parameter int X_MIN      = 16,
  parameter int X_MAX      = 623,
  parameter int Y_MIN      = 16,
  parameter int Y_MAX      = 463,
  parameter int STEP       = 2,
  parameter int START_X    = 320,
  parameter int START_Y    = 240,
  parameter int ANIM_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       pause,
  output logic [9:0] midx,
  output logic [9:0] midy,
  output logic [1:0] dir,
  output logic       mouth_open,
  output logic       moving
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MOVE    = 2'd1;
  localparam logic [1:0] S_BLOCKED = 2'd2;
  localparam logic [1:0] S_PAUSED  = 2'd3;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam int CNT_W = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_TICKS - 1);

  // 11-bit copies for bound compares so that nothing can wrap
  localparam logic [10:0] X_MIN_W = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_W = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);
  localparam logic [10:0] STEP_W  = 11'(STEP);

  localparam logic [9:0] X_MIN_P = 10'(X_MIN);
  localparam logic [9:0] X_MAX_P = 10'(X_MAX);
  localparam logic [9:0] Y_MIN_P = 10'(Y_MIN);
  localparam logic [9:0] Y_MAX_P = 10'(Y_MAX);
  localparam logic [9:0] STEP_P  = 10'(STEP);

  logic [1:0]       state;
  logic [1:0]       pre_state;
  logic             pend_valid;
  logic [1:0]       pend_dir;
  logic [CNT_W-1:0] anim_cnt;

  logic       btn_any;
  logic [1:0] btn_dir;
  logic       req_valid;
  logic [1:0] req_dir;
  logic       take_req;
  logic       do_step;
  logic [1:0] new_dir;
  logic [9:0] step_x;
  logic [9:0] step_y;
  logic       step_hit;
  logic [10:0] x_w;
  logic [10:0] y_w;

  assign btn_any = btn_up | btn_down | btn_left | btn_right;

  always_comb begin
    btn_dir = DIR_RIGHT;
    if (btn_up)        btn_dir = DIR_UP;
    else if (btn_down) btn_dir = DIR_DOWN;
    else if (btn_left) btn_dir = DIR_LEFT;
  end

  // live buttons take precedence over the latched request
  assign req_valid = btn_any | pend_valid;
  assign req_dir   = btn_any ? btn_dir : pend_dir;

  always_comb begin
    take_req = 1'b0;
    do_step  = 1'b0;
    case (state)
      S_IDLE: begin
        take_req = req_valid;
        do_step  = req_valid;
      end
      S_MOVE: begin
        take_req = req_valid;
        do_step  = 1'b1;
      end
      S_BLOCKED: begin
        // a request back into the wall we are resting on is swallowed
        take_req = req_valid && (req_dir != dir);
        do_step  = take_req;
      end
      default: begin
        take_req = 1'b0;
        do_step  = 1'b0;
      end
    endcase
  end

  assign new_dir = take_req ? req_dir : dir;
  assign x_w     = {1'b0, midx};
  assign y_w     = {1'b0, midy};

  // decrement guard compares against MIN+STEP so the subtraction is only
  // used when it cannot go below the bound
  always_comb begin
    step_x   = midx;
    step_y   = midy;
    step_hit = 1'b0;
    case (new_dir)
      DIR_RIGHT: begin
        if (x_w + STEP_W >= X_MAX_W) begin
          step_x   = X_MAX_P;
          step_hit = 1'b1;
        end else begin
          step_x = midx + STEP_P;
        end
      end
      DIR_LEFT: begin
        if (x_w <= X_MIN_W + STEP_W) begin
          step_x   = X_MIN_P;
          step_hit = 1'b1;
        end else begin
          step_x = midx - STEP_P;
        end
      end
      DIR_UP: begin
        if (y_w <= Y_MIN_W + STEP_W) begin
          step_y   = Y_MIN_P;
          step_hit = 1'b1;
        end else begin
          step_y = midy - STEP_P;
        end
      end
      default: begin
        if (y_w + STEP_W >= Y_MAX_W) begin
          step_y   = Y_MAX_P;
          step_hit = 1'b1;
        end else begin
          step_y = midy + STEP_P;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pre_state  <= S_IDLE;
      pend_valid <= 1'b0;
      pend_dir   <= DIR_RIGHT;
      anim_cnt   <= '0;
      midx       <= 10'(START_X);
      midy       <= 10'(START_Y);
      dir        <= DIR_RIGHT;
      mouth_open <= 1'b1;
      moving     <= 1'b0;
    end else begin
      if (btn_any) begin
        pend_valid <= 1'b1;
        pend_dir   <= btn_dir;
      end

      if (state != S_PAUSED && pause) begin
        // pause wins over a coincident tick
        pre_state <= state;
        state     <= S_PAUSED;
        moving    <= 1'b0;
      end else if (state == S_PAUSED) begin
        if (!pause) begin
          state  <= pre_state;
          moving <= (pre_state == S_MOVE);
        end
      end else if (frame_tick) begin
        // a processed tick always consumes the latch, overriding the load above
        pend_valid <= 1'b0;
        if (do_step) begin
          dir  <= new_dir;
          midx <= step_x;
          midy <= step_y;
          if (step_hit) begin
            state      <= S_BLOCKED;
            moving     <= 1'b0;
            mouth_open <= 1'b1;
            anim_cnt   <= '0;
          end else begin
            state  <= S_MOVE;
            moving <= 1'b1;
            if (state == S_MOVE) begin
              if (anim_cnt == CNT_LAST) begin
                anim_cnt   <= '0;
                mouth_open <= ~mouth_open;
              end else begin
                anim_cnt <= anim_cnt + CNT_W'(1);
              end
            end
          end
        end
      end
    end
  end

endmodule
